// File: rtl/lc3b_divider.sv
// rtl/lc3b_divider.sv - multi-cycle restoring shift-subtract divider with start/done handshake
module lc3b_divider #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] r;       // partial remainder, always < divisor between steps
    logic [WIDTH-1:0] dq;      // dividend bits shift out the top, quotient bits shift in
    logic [WIDTH-1:0] dvsr;    // divisor magnitude
    logic             neg_q;
    logic             neg_r;

    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH:0]   r_shift;
    logic             fits;
    logic [WIDTH-1:0] r_diff;
    logic [WIDTH-1:0] r_new;
    logic [WIDTH-1:0] q_new;

    // Operand magnitudes and one restoring iteration step
    always_comb begin
        a_neg   = signed_op & a[WIDTH-1];
        b_neg   = signed_op & b[WIDTH-1];
        a_mag   = a_neg ? -a : a;
        b_mag   = b_neg ? -b : b;
        r_shift = {r, dq[WIDTH-1]};
        fits    = (r_shift >= {1'b0, dvsr});
        // When fits is true the difference is below dvsr, so the top bit is always zero
        r_diff  = r_shift[WIDTH-1:0] - dvsr;
        r_new   = fits ? r_diff : r_shift[WIDTH-1:0];
        q_new   = {dq[WIDTH-2:0], fits};
    end

    // Control FSM, iteration datapath and registered result outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            count       <= '0;
            r           <= '0;
            dq          <= '0;
            dvsr        <= '0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        div_by_zero <= 1'b0;
                        if (b == '0) begin
                            quotient    <= '1;
                            remainder   <= a;
                            div_by_zero <= 1'b1;
                            done        <= 1'b1;
                            busy        <= 1'b0;
                            state       <= DONE;
                        end else begin
                            dq    <= a_mag;
                            dvsr  <= b_mag;
                            r     <= '0;
                            count <= '0;
                            neg_q <= a_neg ^ b_neg;
                            neg_r <= a_neg;
                            busy  <= 1'b1;
                            state <= RUN;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    r     <= r_new;
                    dq    <= q_new;
                    count <= count + 1'b1;
                    if (count == LAST) begin
                        quotient  <= neg_q ? -q_new : q_new;
                        remainder <= neg_r ? -r_new : r_new;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state     <= DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lc3b_divider.sv
// tb/tb_lc3b_divider.sv - self-checking bench for lc3b_divider against an arithmetic model
module tb_lc3b_divider;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        signed_op;
    logic [15:0] a;
    logic [15:0] b;
    logic        busy;
    logic        done;
    logic [15:0] quotient;
    logic [15:0] remainder;
    logic        div_by_zero;

    int checks;
    int errors;

    lc3b_divider #(.WIDTH(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .signed_op   (signed_op),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain integer division truncating toward zero
    function automatic void model(input logic s, input logic [15:0] x, input logic [15:0] y,
                                  output logic [15:0] q, output logic [15:0] r, output logic dz);
        int sx;
        int sy;
        int q32;
        int r32;
        if (y == 16'h0) begin
            q  = 16'hFFFF;
            r  = x;
            dz = 1'b1;
        end else if (s) begin
            sx  = int'($signed(x));
            sy  = int'($signed(y));
            q32 = sx / sy;
            r32 = sx % sy;
            q   = q32[15:0];
            r   = r32[15:0];
            dz  = 1'b0;
        end else begin
            q  = x / y;
            r  = x % y;
            dz = 1'b0;
        end
    endfunction

    // Drives one divide and measures latency (edges after the accepting edge) and results
    task automatic run_div(input logic s, input logic [15:0] x, input logic [15:0] y,
                           output logic [15:0] q, output logic [15:0] r, output logic dz,
                           output int lat, output logic overlap, output logic done_after);
        @(negedge clk);
        signed_op = s;
        a         = x;
        b         = y;
        start     = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat        = -1;
        overlap    = 1'b0;
        q          = 16'h0;
        r          = 16'h0;
        dz         = 1'b0;
        done_after = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (busy && done) overlap = 1'b1;
            if (done) begin
                lat = i;
                q   = quotient;
                r   = remainder;
                dz  = div_by_zero;
                break;
            end
        end
        @(negedge clk);
        done_after = done;
    endtask

    task automatic check_div(input string name, input logic s, input logic [15:0] x,
                             input logic [15:0] y);
        logic [15:0] q;
        logic [15:0] r;
        logic        dz;
        logic [15:0] eq;
        logic [15:0] er;
        logic        edz;
        int          lat;
        int          elat;
        logic        ov;
        logic        da;
        model(s, x, y, eq, er, edz);
        elat = (y == 16'h0) ? 0 : 16;
        run_div(s, x, y, q, r, dz, lat, ov, da);
        checks++;
        if (lat !== elat) begin
            errors++;
            $display("FAIL %s latency: got %0d expected %0d (s=%0b a=%h b=%h)", name, lat, elat, s, x, y);
        end
        checks++;
        if (q !== eq || r !== er || dz !== edz) begin
            errors++;
            $display("FAIL %s result: got q=%h r=%h dz=%b expected q=%h r=%h dz=%b (s=%0b a=%h b=%h)",
                     name, q, r, dz, eq, er, edz, s, x, y);
        end
        checks++;
        if (ov !== 1'b0 || da !== 1'b0) begin
            errors++;
            $display("FAIL %s handshake: busy&done=%b done_next=%b expected 0 0", name, ov, da);
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        start     = 1'b0;
        signed_op = 1'b0;
        a         = 16'h0;
        b         = 16'h0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({busy, done, quotient, remainder, div_by_zero} !== 35'h0) begin
            errors++;
            $display("FAIL reset_state: got busy=%b done=%b q=%h r=%h dz=%b expected all 0",
                     busy, done, quotient, remainder, div_by_zero);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        check_div("unsigned_100_7", 1'b0, 16'd100, 16'd7);
        check_div("signed_m7_2", 1'b1, 16'hFFF9, 16'd2);
        check_div("div_zero", 1'b0, 16'h1234, 16'h0000);
        check_div("after_div_zero", 1'b0, 16'd9, 16'd3);
        check_div("signed_overflow", 1'b1, 16'h8000, 16'hFFFF);
        check_div("unsigned_max_1", 1'b0, 16'hFFFF, 16'h0001);
        check_div("signed_div_zero", 1'b1, 16'h8001, 16'h0000);
        check_div("signed_neg_neg", 1'b1, 16'h8000, 16'h8000);
    endtask

    task automatic test_dbz_clear_on_accept();
        check_div("dz_setup", 1'b0, 16'h0042, 16'h0000);
        @(negedge clk);
        signed_op = 1'b0;
        a         = 16'd50;
        b         = 16'd5;
        start     = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        checks++;
        if (div_by_zero !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL dz_clear: got dz=%b busy=%b expected dz=0 busy=1", div_by_zero, busy);
        end
        repeat (20) @(negedge clk);
    endtask

    task automatic test_random();
        logic        s;
        logic [15:0] x;
        logic [15:0] y;
        for (int n = 0; n < 40; n++) begin
            s = 1'($urandom_range(0, 1));
            x = 16'($urandom);
            y = 16'($urandom);
            case ($urandom_range(0, 7))
                0: y = 16'h0;
                1: y = 16'($urandom_range(1, 5));
                2: x = 16'h8000;
                3: y = 16'hFFFF;
                default: ;
            endcase
            check_div("random", s, x, y);
        end
    endtask

    task automatic test_back_to_back();
        int          lat;
        logic [15:0] eq;
        logic [15:0] er;
        logic        edz;
        // first divide, with a second start pulse mid-run that must be ignored
        @(negedge clk);
        signed_op = 1'b0;
        a         = 16'd5;
        b         = 16'd2;
        start     = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (5) @(negedge clk);
        a     = 16'd9;
        b     = 16'd3;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) begin
                lat = i;
                break;
            end
        end
        checks++;
        if (lat !== 11 || quotient !== 16'd2 || remainder !== 16'd1) begin
            errors++;
            $display("FAIL ignore_busy_start: got lat=%0d q=%h r=%h expected lat=11 q=0002 r=0001",
                     lat, quotient, remainder);
        end
        // start during the DONE cycle is accepted
        model(1'b1, 16'hFF9C, 16'd7, eq, er, edz);
        signed_op = 1'b1;
        a         = 16'hFF9C;
        b         = 16'd7;
        start     = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        lat = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) begin
                lat = i;
                break;
            end
        end
        checks++;
        if (lat !== 16 || quotient !== eq || remainder !== er || div_by_zero !== edz) begin
            errors++;
            $display("FAIL start_in_done: got lat=%0d q=%h r=%h dz=%b expected lat=16 q=%h r=%h dz=%b",
                     lat, quotient, remainder, div_by_zero, eq, er, edz);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        logic seen;
        check_div("pre_reset", 1'b0, 16'd1000, 16'd33);
        @(negedge clk);
        signed_op = 1'b0;
        a         = 16'd777;
        b         = 16'd5;
        start     = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, quotient, remainder, div_by_zero} !== 35'h0) begin
            errors++;
            $display("FAIL reset_mid: got busy=%b done=%b q=%h r=%h dz=%b expected all 0",
                     busy, done, quotient, remainder, div_by_zero);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen  = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done || busy) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_done: got activity=%b expected 0", seen);
        end
        check_div("post_reset", 1'b1, 16'hFFF9, 16'd2);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_directed();
        test_dbz_clear_on_accept();
        test_random();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
